// File: rtl/noc_local_ni.sv
// noc_local_ni: local network interface between a core and a router L port (credit-based inject, buffered eject)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   tx_valid/tx_dest_x/tx_dest_y/tx_payload/tx_ready   core request side, packed into {payload,x,y} flits
//   net_data_o/net_enable_o/net_credit_i               flit out to router L input port, credit return
//   net_data_i/net_enable_i/net_credit_o               flit in from router L output port, credit back
//   rx_valid/rx_data/rx_ready                          first-word fall-through eject FIFO head to core
//   ovf_err/credit_err/misroute_err                    sticky error flags
module noc_local_ni #(
    parameter logic [3:0] XCOORD   = 4'd0,
    parameter logic [3:0] YCOORD   = 4'd0,
    parameter int         TX_DEPTH = 4,
    parameter int         RX_DEPTH = 4,
    parameter int         CREDITS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    input  logic [3:0]  tx_dest_x,
    input  logic [3:0]  tx_dest_y,
    input  logic [7:0]  tx_payload,
    output logic        tx_ready,
    output logic [15:0] net_data_o,
    output logic        net_enable_o,
    input  logic        net_credit_i,
    input  logic [15:0] net_data_i,
    input  logic        net_enable_i,
    output logic        net_credit_o,
    output logic        rx_valid,
    output logic [15:0] rx_data,
    input  logic        rx_ready,
    output logic        ovf_err,
    output logic        credit_err,
    output logic        misroute_err
);
    localparam int TW = $clog2(TX_DEPTH);
    localparam int RW = $clog2(RX_DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);
    logic [15:0]   tx_mem [TX_DEPTH];
    logic [15:0]   rx_mem [RX_DEPTH];
    logic [TW:0]   tx_wp, tx_rp;
    logic [RW:0]   rx_wp, rx_rp;
    logic [CW-1:0] credits, credits_nxt;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, send, rx_pop, rx_push;
    // extra MSB on each pointer separates full (MSBs differ) from empty (pointers equal)
    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = tx_wp == {~tx_rp[TW], tx_rp[TW-1:0]};
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = rx_wp == {~rx_rp[RW], rx_rp[RW-1:0]};
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;
    assign send     = !tx_empty && credits != '0;
    assign rx_valid = !rx_empty;
    assign rx_data  = rx_mem[rx_rp[RW-1:0]];
    assign rx_pop   = rx_valid && rx_ready;
    // a full FIFO still takes the write when the head leaves on the same edge
    assign rx_push  = net_enable_i && (!rx_full || rx_pop);
    always_comb begin
        credits_nxt = (send && !net_credit_i) ? credits - CW'(1) :
                      (!send && net_credit_i && credits != CMAX) ? credits + CW'(1) : credits;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp        <= '0;
            tx_rp        <= '0;
            rx_wp        <= '0;
            rx_rp        <= '0;
            credits      <= CMAX;
            net_data_o   <= '0;
            net_enable_o <= 1'b0;
            net_credit_o <= 1'b0;
            ovf_err      <= 1'b0;
            credit_err   <= 1'b0;
            misroute_err <= 1'b0;
        end else begin
            tx_wp        <= tx_wp + (TW+1)'(tx_push);
            tx_rp        <= tx_rp + (TW+1)'(send);
            rx_wp        <= rx_wp + (RW+1)'(rx_push);
            rx_rp        <= rx_rp + (RW+1)'(rx_pop);
            credits      <= credits_nxt;
            net_enable_o <= send;
            net_credit_o <= rx_pop;
            if (send)
                net_data_o <= tx_mem[tx_rp[TW-1:0]];
            if (net_credit_i && !send && credits == CMAX)
                credit_err <= 1'b1;
            if (net_enable_i && rx_full && !rx_pop)
                ovf_err <= 1'b1;
            if (rx_push && net_data_i[7:0] != {XCOORD, YCOORD})
                misroute_err <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp[TW-1:0]] <= {tx_payload, tx_dest_x, tx_dest_y};
        if (rx_push)
            rx_mem[rx_wp[RW-1:0]] <= net_data_i;
    end
endmodule
